stream_mux_n: RTL and testbench
===============================

# stream_mux_n

Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output, and a one-entry registered output stage. It replaces the flat combinational 16:1 bit selector. Defaults N=16 and WIDTH=1 give the same selection function, registered and flow-controlled. It sits between parallel producer channels and a single downstream consumer.

## Interface
- `N`, 16: number of input channels; legal range is N ≥ 2.
- `WIDTH`, 1: data bits per channel.
- `SELW`, localparam, $clog2(N): width of `sel` and `out_ch`.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  N  per-channel valid.
- `in_data`  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `in_ready`  out  N  per-channel ready; combinational, at most one bit high.
- `sel`  in  SELW  channel select, used in fixed mode.
- `out_valid`  out  1  output register holds a word.
- `out_data`  out  WIDTH  registered word.
- `out_ch`  out  SELW  index of the channel that supplied `out_data`.
- `out_ready`  in  1  downstream accepts the word.

## Operation
- A transfer on channel i occurs when `in_valid[i] && in_ready[i]`. An output transfer occurs when `out_valid && out_ready`.
- The load enable is `load = !out_valid || out_ready`, which gives full throughput, one word per cycle.
- Grant (fixed mode):
  - The candidate is `sel`.
  - `in_ready[c] = load` when c < N; all other `in_ready` bits are 0.
  - If `sel` ≥ N (N not a power of two), nothing is granted and no load occurs.
- On load with a granted channel that is valid: `out_data ← in_data[c]`, `out_ch ← c`, `out_valid ← 1`.
- On load with no valid granted channel: `out_valid ← 0`. `out_data` and `out_ch` hold.
- While `out_valid && !out_ready`, `out_data` and `out_ch` are stable and all `in_ready` bits are 0.
- `in_ready` may depend combinationally on `out_ready`, `sel`, and `in_valid` (RR mode). There is no combinational path from `in_data` to any output.
- Reset values: `out_valid` = 0, `out_data` = 0, `out_ch` = 0, RR pointer = 0. All `in_ready` bits are 0 while `rst` is high.
- Reset mid-operation discards the held word. The next load is permitted in the first cycle after `rst` falls.

## Timing
- Latency is 1 cycle: an input accepted on edge k is visible at `out_data` after edge k.
- Simultaneous unload and load in the same cycle is required. A stalled output never drops or duplicates a word.
- A `sel` change while the output is stalled takes effect at the next load. No transfer is aborted.

## Configuration
- Macro: `STREAM_MUX_RR_EN`.
- Defined: round-robin arbitration.
  - The `sel` port is present but ignored.
  - The grant is the first valid channel scanning from `ptr` upward, wrapping at N−1 to 0.
  - `in_ready` is asserted only to that channel, gated by `load`.
  - After each input transfer, `ptr ← (granted + 1) mod N`. With no transfer, `ptr` holds.
  - With no channel valid, no grant is made.
- Undefined: fixed-select mode as in Operation. There is no pointer register.

## Structure
- Package `stream_mux_pkg` holds:
  - default constants `STREAM_MUX_N_DEF` = 16 and `STREAM_MUX_WIDTH_DEF` = 1;
  - a function computing the channel index width.
- Sub-module `stream_rr_arb` (parameter N):
  - inputs: `req[N]`, `advance`, `clk`, `rst`;
  - outputs: one-hot `gnt[N]` and encoded `gnt_idx`;
  - owns the pointer;
  - instantiated only under `STREAM_MUX_RR_EN`.

## Test plan
- Fixed mode, N=16, WIDTH=1, `out_ready` = 1, `in_valid` = all 1s, data = 16'hA5C3, `sel` swept 0..15: `out_data` follows data[sel] one cycle later, and `out_ch` = `sel`.
- Backpressure:
  - Setup: N=4, WIDTH=8, `sel` = 2, ch2 presents 8'h11, 8'h22, 8'h33 back to back, and `out_ready` is low for cycles 2–4.
  - Response: `out_data` holds 8'h22 and `in_ready` = 0 during the stall.
  - Response: the sequence arrives exactly once, in order.
- Out-of-range select, N=5: `sel` = 6 with all valid → `in_ready` = 0 and `out_valid` falls to 0 after the current word drains.
- Reset mid-stall:
  - Setup: `out_valid` = 1 holding 8'h5A, `rst` pulsed for one cycle.
  - Response: the next cycle shows `out_valid` = 0, `out_data` = 0, `out_ch` = 0.
- RR mode, N=4, all valid, `out_ready` = 1:
  - Response: grants follow 0,1,2,3,0. With only ch1 and ch3 valid, grants alternate 1,3,1.
  - Response: after holding `out_ready` low, the grant order resumes without skipping a channel.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

    localparam int STREAM_MUX_N_DEF     = 16;
    localparam int STREAM_MUX_WIDTH_DEF = 1;

    // A channel index is never narrower than one bit, even for N = 2.
    function automatic int chan_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_n_rr.sv
// Round-robin arbiter: first requester at or above the pointer, wrapping at N-1.
// Used by stream_mux_n only when STREAM_MUX_RR_EN is defined.
module stream_rr_arb
    import stream_mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = chan_idx_w(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    gnt,
    output logic [SELW-1:0] gnt_idx
);

    logic [SELW-1:0] ptr_q, ptr_d;
    logic [SELW:0]   sum;
    logic [SELW-1:0] cand;
    logic            found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr_q} + (SELW+1)'(i);
            if (sum >= (SELW+1)'(N)) sum = sum - (SELW+1)'(N);
            cand = sum[SELW-1:0];
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // The pointer moves just past the channel that actually transferred.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = (gnt_idx == SELW'(N-1)) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream multiplexer with a one-entry registered output.
// Fixed select by default; STREAM_MUX_RR_EN switches to round-robin arbitration.
module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int N     = STREAM_MUX_N_DEF,
    parameter  int WIDTH = STREAM_MUX_WIDTH_DEF,
    localparam int SELW  = chan_idx_w(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    input  logic               out_ready
);

    localparam int NP = 1 << SELW;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SELW-1:0]    out_ch_q, out_ch_d;
    logic               load, take;
    logic [SELW-1:0]    gidx;
    logic [WIDTH-1:0]   data_arr [NP];

    // Padded to a power of two so any index value selects a defined word.
    for (genvar i = 0; i < NP; i++) begin : g_pad
        if (i < N) begin : g_ch
            assign data_arr[i] = in_data[i*WIDTH +: WIDTH];
        end else begin : g_nc
            assign data_arr[i] = '0;
        end
    end

    assign load = !out_valid_q || out_ready;

`ifdef STREAM_MUX_RR_EN
    logic [N-1:0] gnt;
    logic         gnt_any;
    logic         unused_sel;

    assign unused_sel = ^sel;
    assign gnt_any    = |gnt;
    assign take       = load && gnt_any && !rst;
    assign in_ready   = (load && !rst) ? gnt : '0;

    stream_rr_arb #(.N(N)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (in_valid),
        .advance (take),
        .gnt     (gnt),
        .gnt_idx (gidx)
    );
`else
    logic [NP-1:0] valid_pad;
    logic          sel_ok;

    for (genvar i = 0; i < NP; i++) begin : g_vpad
        if (i < N) begin : g_ch
            assign valid_pad[i] = in_valid[i];
        end else begin : g_nc
            assign valid_pad[i] = 1'b0;
        end
    end

    if (NP == N) begin : g_pow2
        assign sel_ok = 1'b1;
    end else begin : g_npow2
        assign sel_ok = ({1'b0, sel} < (SELW+1)'(N));
    end

    assign gidx = sel;
    assign take = load && sel_ok && valid_pad[sel] && !rst;

    always_comb begin
        in_ready = '0;
        if (load && sel_ok && !rst) in_ready[sel] = 1'b1;
    end
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        if (load) begin
            out_valid_d = take;
            if (take) begin
                out_data_d = data_arr[gidx];
                out_ch_d   = gidx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Directed bench for stream_mux_n: fixed-select sweep, backpressure, out-of-range
// select, reset mid-stall, and round-robin ordering when STREAM_MUX_RR_EN is set.
module tb_stream_mux_n;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0] valid16, data16, rdy16;
    logic [3:0]  sel16, oc16;
    logic        ov16, ordy16;
    logic [0:0]  od16;

    logic [3:0]  valid4, rdy4;
    logic [31:0] data4;
    logic [1:0]  sel4, oc4;
    logic        ov4, ordy4;
    logic [7:0]  od4;

    logic [4:0]  valid5, rdy5;
    logic [39:0] data5;
    logic [2:0]  sel5, oc5;
    logic        ov5, ordy5;
    logic [7:0]  od5;

    stream_mux_n #(.N(16), .WIDTH(1)) u16 (
        .clk(clk), .rst(rst), .in_valid(valid16), .in_data(data16), .in_ready(rdy16),
        .sel(sel16), .out_valid(ov16), .out_data(od16), .out_ch(oc16), .out_ready(ordy16));

    stream_mux_n #(.N(4), .WIDTH(8)) u4 (
        .clk(clk), .rst(rst), .in_valid(valid4), .in_data(data4), .in_ready(rdy4),
        .sel(sel4), .out_valid(ov4), .out_data(od4), .out_ch(oc4), .out_ready(ordy4));

    stream_mux_n #(.N(5), .WIDTH(8)) u5 (
        .clk(clk), .rst(rst), .in_valid(valid5), .in_data(data5), .in_ready(rdy5),
        .sel(sel5), .out_valid(ov5), .out_data(od5), .out_ch(oc5), .out_ready(ordy5));

    int nvec = 0;
    int nbad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Words leaving u4 are logged on the falling edge before the edge that moves them.
    logic [7:0] drained[$];
    logic       mon4 = 1'b0;
    always @(negedge clk) begin
        if (mon4 && ov4 && ordy4) drained.push_back(od4);
    end

    typedef struct {
        logic [3:0] sel;
        logic       exp_d;
    } sweep_t;

    typedef struct {
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic [1:0] exp_ch;
    } rr_t;

    sweep_t sweep[16];
    rr_t    rr[13];

    initial begin
        // 16'hA5C3, bit by bit from bit 0
        sweep[0]  = '{4'd0,  1'b1}; sweep[1]  = '{4'd1,  1'b1}; sweep[2]  = '{4'd2,  1'b0}; sweep[3]  = '{4'd3,  1'b0};
        sweep[4]  = '{4'd4,  1'b0}; sweep[5]  = '{4'd5,  1'b0}; sweep[6]  = '{4'd6,  1'b1}; sweep[7]  = '{4'd7,  1'b1};
        sweep[8]  = '{4'd8,  1'b1}; sweep[9]  = '{4'd9,  1'b0}; sweep[10] = '{4'd10, 1'b1}; sweep[11] = '{4'd11, 1'b0};
        sweep[12] = '{4'd12, 1'b0}; sweep[13] = '{4'd13, 1'b1}; sweep[14] = '{4'd14, 1'b0}; sweep[15] = '{4'd15, 1'b1};

        rr[0]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        rr[1]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
        rr[2]  = '{4'b1111, 1'b1, 4'b0100, 2'd2};
        rr[3]  = '{4'b1111, 1'b1, 4'b1000, 2'd3};
        rr[4]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
        rr[5]  = '{4'b1010, 1'b1, 4'b0010, 2'd1};
        rr[6]  = '{4'b1010, 1'b1, 4'b1000, 2'd3};
        rr[7]  = '{4'b1010, 1'b1, 4'b0010, 2'd1};
        rr[8]  = '{4'b1111, 1'b0, 4'b0000, 2'd1};
        rr[9]  = '{4'b1111, 1'b0, 4'b0000, 2'd1};
        rr[10] = '{4'b1111, 1'b1, 4'b0100, 2'd2};
        rr[11] = '{4'b1111, 1'b1, 4'b1000, 2'd3};
        rr[12] = '{4'b1111, 1'b1, 4'b0001, 2'd0};

        rst = 1'b1;
        valid16 = '1; data16 = 16'hA5C3; sel16 = 4'd7; ordy16 = 1'b1;
        valid4  = '1; data4  = 32'h44332211; sel4 = 2'd2; ordy4 = 1'b1;
        valid5  = '0; data5  = 40'h5544332211; sel5 = 3'd1; ordy5 = 1'b1;

        tick();
        tick();
        chk("rst_in_ready16", rdy16, 32'h0);
        chk("rst_in_ready4", rdy4, 32'h0);
        chk("rst_out_valid16", ov16, 32'h0);
        chk("rst_out_data16", od16, 32'h0);
        chk("rst_out_ch16", oc16, 32'h0);
        chk("rst_out_valid4", ov4, 32'h0);
        chk("rst_out_data4", od4, 32'h0);
        chk("rst_out_ch4", oc4, 32'h0);
        rst = 1'b0;
        valid16 = '0;
        valid4 = '0;
        tick();

`ifndef STREAM_MUX_RR_EN
        valid16 = '1;
        ordy16 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            sel16 = sweep[i].sel;
            #1;
            chk("sweep_in_ready", rdy16, 32'h1 << sweep[i].sel);
            tick();
            chk("sweep_out_valid", ov16, 32'h1);
            chk("sweep_out_data", od16, {31'h0, sweep[i].exp_d});
            chk("sweep_out_ch", oc16, {28'h0, sweep[i].sel});
        end
        valid16 = '0;

        // Backpressure on channel 2 of the 4x8 instance.
        drained.delete();
        mon4 = 1'b1;
        sel4 = 2'd2; valid4 = 4'b0100; ordy4 = 1'b1;
        data4 = 32'h00110000; #1;
        chk("bp_ready_w1", rdy4, 32'h4);
        tick();
        chk("bp_data_w1", od4, 32'h11);
        data4 = 32'h00220000; #1;
        chk("bp_ready_w2", rdy4, 32'h4);
        tick();
        chk("bp_data_w2", od4, 32'h22);
        data4 = 32'h00330000; ordy4 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp_stall_ready", rdy4, 32'h0);
            tick();
            chk("bp_stall_valid", ov4, 32'h1);
            chk("bp_stall_data", od4, 32'h22);
            chk("bp_stall_ch", oc4, 32'h2);
        end
        ordy4 = 1'b1; #1;
        chk("bp_release_ready", rdy4, 32'h4);
        tick();
        chk("bp_data_w3", od4, 32'h33);
        valid4 = '0;
        tick();
        chk("bp_drained_valid", ov4, 32'h0);
        tick();
        mon4 = 1'b0;
        chk("bp_drain_count", drained.size(), 32'd3);
        if (drained.size() == 3) begin
            chk("bp_order0", drained[0], 32'h11);
            chk("bp_order1", drained[1], 32'h22);
            chk("bp_order2", drained[2], 32'h33);
        end

        // Out-of-range select on the 5-channel instance.
        valid5 = '1; ordy5 = 1'b1; sel5 = 3'd1; #1;
        chk("oor_ready_sel1", rdy5, 32'h02);
        tick();
        chk("oor_data_sel1", od5, 32'h22);
        chk("oor_ch_sel1", oc5, 32'h1);
        sel5 = 3'd4; #1;
        chk("oor_ready_sel4", rdy5, 32'h10);
        tick();
        chk("oor_data_sel4", od5, 32'h55);
        chk("oor_ch_sel4", oc5, 32'h4);
        sel5 = 3'd6; ordy5 = 1'b0; #1;
        chk("oor_ready_stall", rdy5, 32'h0);
        tick();
        chk("oor_valid_held", ov5, 32'h1);
        chk("oor_data_held", od5, 32'h55);
        ordy5 = 1'b1; #1;
        chk("oor_ready_sel6", rdy5, 32'h0);
        tick();
        chk("oor_valid_drop", ov5, 32'h0);
        chk("oor_data_keep", od5, 32'h55);
        chk("oor_ch_keep", oc5, 32'h4);
        valid5 = '0;

        // Reset while a word is stalled in u4.
        sel4 = 2'd2; valid4 = 4'b0100; data4 = 32'h005A0000; ordy4 = 1'b1;
        tick();
        valid4 = '0; ordy4 = 1'b0;
        tick();
        chk("rs_valid_held", ov4, 32'h1);
        chk("rs_data_held", od4, 32'h5A);
        rst = 1'b1; valid4 = 4'b0100; ordy4 = 1'b1; #1;
        chk("rs_ready_in_rst", rdy4, 32'h0);
        tick();
        rst = 1'b0;
        chk("rs_valid_cleared", ov4, 32'h0);
        chk("rs_data_cleared", od4, 32'h0);
        chk("rs_ch_cleared", oc4, 32'h0);
        data4 = 32'h00660000; #1;
        chk("rs_ready_after", rdy4, 32'h4);
        tick();
        chk("rs_first_load_valid", ov4, 32'h1);
        chk("rs_first_load_data", od4, 32'h66);
        chk("rs_first_load_ch", oc4, 32'h2);
        valid4 = '0;
`else
        data4 = 32'h44332211;
        sel4 = 2'd3;
        for (int i = 0; i < 13; i++) begin
            valid4 = rr[i].valid;
            ordy4  = rr[i].ordy;
            #1;
            chk("rr_in_ready", rdy4, {28'h0, rr[i].exp_rdy});
            tick();
            chk("rr_out_valid", ov4, 32'h1);
            chk("rr_out_ch", oc4, {30'h0, rr[i].exp_ch});
            chk("rr_out_data", od4, 32'h11 * (rr[i].exp_ch + 32'h1));
        end
        valid4 = '0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
